// File: rtl/pdp8_core.sv
// PDP-8 processor core: datapath, sequencing FSM and EAE (MQ) operates.
// Talks to a front panel (switches/buttons/run) and to a 4096x12 memory
// controller over a request/finish handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// HALTED     | idle; front-panel buttons honoured, run_sw starts fetching
// FETCH_1    | issue instruction read at pc
// FETCH_2    | wait for instruction word, latch IR, advance pc
// DECODE     | form EA, start indirect or issue operand / operate / jump
// IND_1      | issue pointer read at EA
// IND_2      | wait for pointer; pointer becomes EA (or autoincrement)
// AUTOINC_WR | write incremented pointer back to 0o0010-0o0017
// OPER_RD    | wait for operand read (AND, TAD, ISZ)
// OPER_WR    | wait for operand write (ISZ, DCA, JMS)
// EXECUTE    | apply operate instruction (group 1/2/3)
// DEPOSIT_WR | front-panel deposit of switch_reg at mem[pc]
module pdp8_core #(
    parameter logic [11:0] RESET_PC = 12'o0200
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [11:0] switch_reg,
    input  logic        load_pc,
    input  logic        deposit,
    input  logic        run_sw,
    output logic        running,
    output logic [11:0] address,
    output logic        read_enable,
    output logic        write_enable,
    output logic [11:0] write_data,
    input  logic [11:0] read_data,
    input  logic        mem_finished,
    output logic [3:0]  curr_state,
    output logic [11:0] pc,
    output logic [11:0] ac,
    output logic [11:0] mq,
    output logic        link
);

    typedef enum logic [3:0] {
        HALTED     = 4'd0,
        FETCH_1    = 4'd1,
        FETCH_2    = 4'd2,
        DECODE     = 4'd3,
        IND_1      = 4'd4,
        IND_2      = 4'd5,
        AUTOINC_WR = 4'd6,
        OPER_RD    = 4'd7,
        OPER_WR    = 4'd8,
        EXECUTE    = 4'd9,
        DEPOSIT_WR = 4'd10
    } state_t;

    state_t      state;
    logic [11:0] ir;
    logic [4:0]  ir_page;
    logic [11:0] ea;
    logic        ind_done;
    logic        load_pc_q;
    logic        deposit_q;

    logic [2:0]  opcode;
    logic [11:0] ea_calc;
    logic [11:0] oper_ea;
    logic [12:0] tad_sum;
    logic        load_rise;
    logic        deposit_rise;

    logic [11:0] opr_ac;
    logic [11:0] opr_mq;
    logic        opr_link;
    logic        opr_skip;
    logic        opr_halt;
    logic [12:0] rot;
    logic        cond;

    assign opcode       = ir[11:9];
    assign ea_calc      = {(ir[7] ? ir_page : 5'b0), ir[6:0]};
    // once an indirect chain has finished, the resolved pointer lives in ea
    assign oper_ea      = ind_done ? ea : ea_calc;
    assign tad_sum      = {1'b0, ac} + {1'b0, read_data};
    assign load_rise    = load_pc & ~load_pc_q;
    assign deposit_rise = deposit & ~deposit_q;
    assign running      = (state != HALTED);
    assign curr_state   = state;

    // operate-instruction result for groups 1, 2 and 3
    always_comb begin
        opr_ac   = ac;
        opr_mq   = mq;
        opr_link = link;
        opr_skip = 1'b0;
        opr_halt = 1'b0;
        rot      = {link, ac};
        cond     = 1'b0;
        if (!ir[8]) begin
            if (ir[7]) rot[11:0] = 12'd0;
            if (ir[6]) rot[12]   = 1'b0;
            if (ir[5]) rot[11:0] = ~rot[11:0];
            if (ir[4]) rot[12]   = ~rot[12];
            if (ir[0]) rot       = rot + 13'd1;
            if (ir[3]) begin
                rot = {rot[0], rot[12:1]};
                if (ir[1]) rot = {rot[0], rot[12:1]};
            end else if (ir[2]) begin
                rot = {rot[11:0], rot[12]};
                if (ir[1]) rot = {rot[11:0], rot[12]};
            end else if (ir[1]) begin
                rot[11:0] = {rot[5:0], rot[11:6]};
            end
            opr_ac   = rot[11:0];
            opr_link = rot[12];
        end else if (!ir[0]) begin
            // the skip sense is evaluated on the accumulator before CLA/OSR
            cond     = (ir[6] & ac[11]) | (ir[5] & (ac == 12'd0)) | (ir[4] & link);
            opr_skip = ir[3] ? ~cond : cond;
            if (ir[7]) opr_ac = 12'd0;
            if (ir[2]) opr_ac = opr_ac | switch_reg;
            opr_halt = ir[1];
        end else begin
            if (ir[7]) opr_ac = 12'd0;
            if (ir[6] && ir[4]) begin
                opr_mq = opr_ac;
                opr_ac = mq;
            end else if (ir[6]) begin
                opr_ac = opr_ac | mq;
            end else if (ir[4]) begin
                opr_mq = opr_ac;
                opr_ac = 12'd0;
            end
        end
    end

    // sequencing FSM and architectural register updates
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state        <= HALTED;
            pc           <= RESET_PC;
            ac           <= 12'd0;
            mq           <= 12'd0;
            link         <= 1'b0;
            address      <= 12'd0;
            write_data   <= 12'd0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            ir           <= 12'd0;
            ir_page      <= 5'd0;
            ea           <= 12'd0;
            ind_done     <= 1'b0;
            load_pc_q    <= 1'b0;
            deposit_q    <= 1'b0;
        end else begin
            load_pc_q <= load_pc;
            deposit_q <= deposit;
            case (state)
                HALTED: begin
                    if (deposit_rise) begin
                        address      <= pc;
                        write_data   <= switch_reg;
                        write_enable <= 1'b1;
                        state        <= DEPOSIT_WR;
                    end else if (load_rise) begin
                        pc <= switch_reg;
                    end else if (run_sw) begin
                        state <= FETCH_1;
                    end
                end
                DEPOSIT_WR: begin
                    if (mem_finished) begin
                        write_enable <= 1'b0;
                        pc           <= pc + 12'd1;
                        state        <= HALTED;
                    end
                end
                FETCH_1: begin
                    address     <= pc;
                    read_enable <= 1'b1;
                    state       <= FETCH_2;
                end
                FETCH_2: begin
                    if (mem_finished) begin
                        read_enable <= 1'b0;
                        ir          <= read_data;
                        ir_page     <= pc[11:7];
                        pc          <= pc + 12'd1;
                        ind_done    <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    if (opcode == 3'd7) begin
                        state <= EXECUTE;
                    end else if (opcode == 3'd6) begin
                        state <= run_sw ? FETCH_1 : HALTED;
                    end else if (ir[8] && !ind_done) begin
                        ea    <= ea_calc;
                        state <= IND_1;
                    end else begin
                        ea <= oper_ea;
                        case (opcode)
                            3'd3: begin
                                address      <= oper_ea;
                                write_data   <= ac;
                                write_enable <= 1'b1;
                                state        <= OPER_WR;
                            end
                            3'd4: begin
                                address      <= oper_ea;
                                write_data   <= pc;
                                write_enable <= 1'b1;
                                state        <= OPER_WR;
                            end
                            3'd5: begin
                                pc    <= oper_ea;
                                state <= run_sw ? FETCH_1 : HALTED;
                            end
                            default: begin
                                address     <= oper_ea;
                                read_enable <= 1'b1;
                                state       <= OPER_RD;
                            end
                        endcase
                    end
                end
                IND_1: begin
                    address     <= ea;
                    read_enable <= 1'b1;
                    state       <= IND_2;
                end
                IND_2: begin
                    if (mem_finished) begin
                        read_enable <= 1'b0;
                        if (ea[11:3] == 9'o001) begin
                            ea           <= read_data + 12'd1;
                            write_data   <= read_data + 12'd1;
                            write_enable <= 1'b1;
                            state        <= AUTOINC_WR;
                        end else begin
                            ea       <= read_data;
                            ind_done <= 1'b1;
                            state    <= DECODE;
                        end
                    end
                end
                AUTOINC_WR: begin
                    if (mem_finished) begin
                        write_enable <= 1'b0;
                        ind_done     <= 1'b1;
                        state        <= DECODE;
                    end
                end
                OPER_RD: begin
                    if (mem_finished) begin
                        read_enable <= 1'b0;
                        case (opcode)
                            3'd0: begin
                                ac    <= ac & read_data;
                                state <= run_sw ? FETCH_1 : HALTED;
                            end
                            3'd1: begin
                                ac    <= tad_sum[11:0];
                                link  <= link ^ tad_sum[12];
                                state <= run_sw ? FETCH_1 : HALTED;
                            end
                            default: begin
                                write_data   <= read_data + 12'd1;
                                write_enable <= 1'b1;
                                state        <= OPER_WR;
                            end
                        endcase
                    end
                end
                OPER_WR: begin
                    if (mem_finished) begin
                        write_enable <= 1'b0;
                        if (opcode == 3'd3) ac <= 12'd0;
                        if (opcode == 3'd4) pc <= ea + 12'd1;
                        if (opcode == 3'd2 && write_data == 12'd0) pc <= pc + 12'd1;
                        state <= run_sw ? FETCH_1 : HALTED;
                    end
                end
                EXECUTE: begin
                    ac   <= opr_ac;
                    mq   <= opr_mq;
                    link <= opr_link;
                    if (opr_skip) pc <= pc + 12'd1;
                    if (opr_halt) state <= HALTED;
                    else          state <= run_sw ? FETCH_1 : HALTED;
                end
                default: state <= HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_pdp8_core.sv
// Directed bench for pdp8_core: small programs run against a behavioural
// 4096x12 memory with a fixed-latency request/finish handshake.
module tb_pdp8_core;

    localparam int MEM_LAT = 1;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [11:0] switch_reg = 12'd0;
    logic        load_pc = 1'b0;
    logic        deposit = 1'b0;
    logic        run_sw = 1'b0;
    logic        running;
    logic [11:0] address;
    logic        read_enable;
    logic        write_enable;
    logic [11:0] write_data;
    logic [11:0] read_data = 12'd0;
    logic        mem_finished = 1'b0;
    logic [3:0]  curr_state;
    logic [11:0] pc, ac, mq;
    logic        link;

    logic [11:0] mem [0:4095];
    int          lat_cnt = 0;
    int          wr_count = 0;
    int          fetch_count = 0;
    int          both_err = 0;
    logic [11:0] last_wa = 12'd0;
    logic [11:0] last_wd = 12'd0;

    int n_cmp = 0;
    int n_bad = 0;
    int w0, f0;

    pdp8_core #(.RESET_PC(12'o0200)) dut (
        .clock(clock), .resetN(resetN), .switch_reg(switch_reg),
        .load_pc(load_pc), .deposit(deposit), .run_sw(run_sw),
        .running(running), .address(address), .read_enable(read_enable),
        .write_enable(write_enable), .write_data(write_data),
        .read_data(read_data), .mem_finished(mem_finished),
        .curr_state(curr_state), .pc(pc), .ac(ac), .mq(mq), .link(link)
    );

    always #5 clock = ~clock;

    // behavioural memory: one finish pulse per request, then a dead cycle
    always @(posedge clock) begin
        mem_finished <= 1'b0;
        if (!mem_finished && (read_enable || write_enable)) begin
            if (lat_cnt == MEM_LAT) begin
                lat_cnt      <= 0;
                mem_finished <= 1'b1;
                if (write_enable) begin
                    mem[address] <= write_data;
                    wr_count     <= wr_count + 1;
                    last_wa      <= address;
                    last_wd      <= write_data;
                end else begin
                    read_data <= mem[address];
                    if (curr_state == 4'd2) fetch_count <= fetch_count + 1;
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    // both enables high together is a protocol error
    always @(negedge clock) begin
        if (read_enable && write_enable) both_err <= both_err + 1;
    end

    task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %o expected %o", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_load(input logic [11:0] sw);
        switch_reg = sw;
        load_pc = 1'b1;
        tick(2);
        load_pc = 1'b0;
        tick(2);
    endtask

    task automatic pulse_deposit(input logic [11:0] sw);
        switch_reg = sw;
        deposit = 1'b1;
        tick(2);
        deposit = 1'b0;
        tick(10);
    endtask

    // run until the core drops back to HALTED, bounded
    task automatic run_to_halt(input string tag);
        int cyc;
        cyc = 0;
        run_sw = 1'b1;
        while (!running && cyc < 50) begin
            tick(1);
            cyc++;
        end
        while (running && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        run_sw = 1'b0;
        check_eq({tag, "_halted"}, {11'd0, running}, 12'd0);
        tick(1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 12'd0;
        tick(3);
        resetN = 1'b1;
        tick(2);

        check_eq("rst_pc", pc, 12'o0200);
        check_eq("rst_ac", ac, 12'd0);
        check_eq("rst_mq", mq, 12'd0);
        check_eq("rst_link", {11'd0, link}, 12'd0);
        check_eq("rst_state", {8'd0, curr_state}, 12'd0);
        check_eq("rst_running", {11'd0, running}, 12'd0);
        check_eq("rst_enables", {10'd0, read_enable, write_enable}, 12'd0);

        w0 = wr_count;
        pulse_deposit(12'o7200);
        check_eq("dep_count", 12'(wr_count - w0), 12'd1);
        check_eq("dep_addr", last_wa, 12'o0200);
        check_eq("dep_data", last_wd, 12'o7200);
        check_eq("dep_mem", mem[12'o0200], 12'o7200);
        check_eq("dep_pc", pc, 12'o0201);

        pulse_load(12'o0300);
        check_eq("ld_pc", pc, 12'o0300);
        check_eq("ld_running", {11'd0, running}, 12'd0);
        check_eq("ld_state", {8'd0, curr_state}, 12'd0);

        // CLA CLL; TAD 205; DCA 206; HLT
        mem[12'o0200] = 12'o7300;
        mem[12'o0201] = 12'o1205;
        mem[12'o0202] = 12'o3206;
        mem[12'o0203] = 12'o7402;
        mem[12'o0205] = 12'o0005;
        mem[12'o0206] = 12'o0000;
        pulse_load(12'o0200);
        f0 = fetch_count;
        run_to_halt("p1");
        check_eq("p1_mem206", mem[12'o0206], 12'o0005);
        check_eq("p1_ac", ac, 12'd0);
        check_eq("p1_pc", pc, 12'o0204);
        check_eq("p1_fetches", 12'(fetch_count - f0), 12'd4);

        // autoincrement: CLA CLL; TAD I 10; TAD I 10; HLT
        mem[12'o0010] = 12'o0100;
        mem[12'o0101] = 12'o0042;
        mem[12'o0102] = 12'o0003;
        mem[12'o0300] = 12'o7300;
        mem[12'o0301] = 12'o1410;
        mem[12'o0302] = 12'o1410;
        mem[12'o0303] = 12'o7402;
        pulse_load(12'o0300);
        run_to_halt("ai");
        check_eq("ai_ptr", mem[12'o0010], 12'o0102);
        check_eq("ai_ac", ac, 12'o0045);
        check_eq("ai_pc", pc, 12'o0304);

        // memory-reference mix: TAD, AND, ISZ skip, JMS, JMP I, DCA
        mem[12'o0400] = 12'o7300;
        mem[12'o0401] = 12'o1220;
        mem[12'o0402] = 12'o0221;
        mem[12'o0403] = 12'o2222;
        mem[12'o0404] = 12'o7402;
        mem[12'o0405] = 12'o4223;
        mem[12'o0406] = 12'o3230;
        mem[12'o0407] = 12'o7402;
        mem[12'o0420] = 12'o7777;
        mem[12'o0421] = 12'o0707;
        mem[12'o0422] = 12'o7777;
        mem[12'o0424] = 12'o1220;
        mem[12'o0425] = 12'o5623;
        pulse_load(12'o0400);
        f0 = fetch_count;
        run_to_halt("mr");
        check_eq("mr_isz", mem[12'o0422], 12'o0000);
        check_eq("mr_jms_ret", mem[12'o0423], 12'o0406);
        check_eq("mr_dca", mem[12'o0430], 12'o0706);
        check_eq("mr_ac", ac, 12'd0);
        check_eq("mr_link", {11'd0, link}, 12'd1);
        check_eq("mr_pc", pc, 12'o0410);
        check_eq("mr_fetches", 12'(fetch_count - f0), 12'd9);

        // CLA CLL CMA; IAC; SNL; HLT(skipped); HLT; then RAL; BSW; HLT
        mem[12'o0500] = 12'o7340;
        mem[12'o0501] = 12'o7001;
        mem[12'o0502] = 12'o7420;
        mem[12'o0503] = 12'o7402;
        mem[12'o0504] = 12'o7402;
        mem[12'o0505] = 12'o7004;
        mem[12'o0506] = 12'o7002;
        mem[12'o0507] = 12'o7402;
        pulse_load(12'o0500);
        run_to_halt("g1a");
        check_eq("iac_ac", ac, 12'd0);
        check_eq("iac_link", {11'd0, link}, 12'd1);
        check_eq("snl_pc", pc, 12'o0505);
        run_to_halt("g1b");
        check_eq("bsw_ac", ac, 12'o0100);
        check_eq("ral_link", {11'd0, link}, 12'd0);
        check_eq("g1b_pc", pc, 12'o0510);

        // EAE: MQL, MQA, SWP
        mem[12'o0600] = 12'o7300;
        mem[12'o0601] = 12'o1220;
        mem[12'o0602] = 12'o7421;
        mem[12'o0603] = 12'o7402;
        mem[12'o0604] = 12'o7501;
        mem[12'o0605] = 12'o7402;
        mem[12'o0606] = 12'o7300;
        mem[12'o0607] = 12'o7001;
        mem[12'o0610] = 12'o7521;
        mem[12'o0611] = 12'o7402;
        mem[12'o0620] = 12'o1234;
        pulse_load(12'o0600);
        run_to_halt("mql");
        check_eq("mql_mq", mq, 12'o1234);
        check_eq("mql_ac", ac, 12'd0);
        run_to_halt("mqa");
        check_eq("mqa_ac", ac, 12'o1234);
        run_to_halt("swp");
        check_eq("swp_ac", ac, 12'o1234);
        check_eq("swp_mq", mq, 12'o0001);
        check_eq("swp_pc", pc, 12'o0612);

        // reset in the middle of an instruction fetch
        run_sw = 1'b1;
        tick(2);
        check_eq("abort_pre_rd", {11'd0, read_enable}, 12'd1);
        #2 resetN = 1'b0;
        #1;
        check_eq("abort_rd", {11'd0, read_enable}, 12'd0);
        check_eq("abort_state", {8'd0, curr_state}, 12'd0);
        check_eq("abort_pc", pc, 12'o0200);
        check_eq("abort_ac", ac, 12'd0);
        check_eq("abort_mq", mq, 12'd0);
        run_sw = 1'b0;
        tick(2);
        resetN = 1'b1;
        tick(2);

        check_eq("no_dual_enable", 12'(both_err), 12'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
